// File: rtl/rat_io_pkg.sv
// Shared types and I/O port map for the RAT MCU top-level wrapper.
package rat_io_pkg;

    // Debounce FSM states
    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_t;

    // Wrapper port IDs
    localparam logic [7:0] SWITCHES_ID  = 8'h20;
    localparam logic [7:0] BTN_CNT_ID   = 8'h21;
    localparam logic [7:0] LEDS_ID      = 8'h40;
    localparam logic [7:0] INTR_CTRL_ID = 8'h41;

    // Bit positions inside the INTR_CTRL_ID output register
    localparam int INTR_EN_BIT = 0;   // interrupt enable level
    localparam int CLR_CNT_BIT = 1;   // write 1 to pulse CLR_CNT

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser and 4-state debounce FSM for one raw button.
// o_press is high for the single cycle in which the FSM is about to enter
// PRESSED, so downstream registers update on the same edge as o_level.
module sync_debounce
    import rat_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // Counter is cleared on entry to a WAIT state, so the terminal value is
    // DEBOUNCE_CYCLES-1 to accept exactly 2+DEBOUNCE_CYCLES edges after capture.
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             w_term;

    assign w_term  = (r_cnt == TERM);
    // Derived only from registers, so no input-to-output combinational path
    assign o_press = (r_state == PRESS_WAIT) && r_sync2 && w_term;
    assign o_level = r_level;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM: a level change is accepted only after a stable run
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            case (r_state)
                RELEASED: begin
                    if (r_sync2) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!r_sync2) begin
                        r_state <= RELEASED;
                        r_cnt   <= '0;
                    end else if (w_term) begin
                        r_state <= PRESSED;
                        r_level <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!r_sync2) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (r_sync2) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (w_term) begin
                        r_state <= RELEASED;
                        r_level <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= RELEASED;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_intr_gen.sv
// Debounced pushbutton interrupt source feeding the RAT MCU INTR input.
// Adds a fixed-width interrupt pulse stretcher and a wrapping press counter
// on top of sync_debounce.
module btn_intr_gen
    import rat_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PULSE_CYCLES    = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTN_IN,
    input  logic       INTR_EN,
    input  logic       CLR_CNT,
    output logic       INTR,
    output logic       BTN_LEVEL,
    output logic [7:0] PRESS_CNT
);

    // PULSE_CYCLES >= 2, so PC_W is at least 1 and holds PULSE_CYCLES-1
    localparam int PC_W = $clog2(PULSE_CYCLES);

    logic            w_press;
    logic            w_level;
    logic            r_intr;
    logic [PC_W-1:0] r_pcnt;
    logic [7:0]      r_press_cnt;

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_btn   (BTN_IN),
        .o_level (w_level),
        .o_press (w_press)
    );

    // Pulse stretcher: a press while enabled (re)loads the remaining count;
    // INTR_EN is only looked at on the press edge, so dropping it mid-pulse
    // never truncates and raising it later never fires retroactively.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_intr <= 1'b0;
            r_pcnt <= '0;
        end else if (w_press && INTR_EN) begin
            r_intr <= 1'b1;
            r_pcnt <= PC_W'(PULSE_CYCLES - 1);
        end else if (r_intr) begin
            if (r_pcnt == '0) r_intr <= 1'b0;
            else              r_pcnt <= r_pcnt - PC_W'(1);
        end
    end

    // Press counter: clear has priority over a coincident press
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)        r_press_cnt <= 8'd0;
        else if (CLR_CNT) r_press_cnt <= 8'd0;
        else if (w_press) r_press_cnt <= r_press_cnt + 8'd1;
    end

    assign INTR      = r_intr;
    assign BTN_LEVEL = w_level;
    assign PRESS_CNT = r_press_cnt;

endmodule

// File: tb/tb_btn_intr_gen.sv
// Bench for btn_intr_gen: two instances (D=4/P=3 and D=2/P=6) checked every
// cycle against a sample-history reference model, plus directed edge checks.
module tb_btn_intr_gen;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       btn1, btn2, en, clr;
    logic       intr1, lvl1, intr2, lvl2;
    logic [7:0] cnt1, cnt2;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    btn_intr_gen #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(3)) dut1 (
        .CLK(CLK), .RESET(RESET), .BTN_IN(btn1), .INTR_EN(en), .CLR_CNT(clr),
        .INTR(intr1), .BTN_LEVEL(lvl1), .PRESS_CNT(cnt1)
    );

    btn_intr_gen #(.DEBOUNCE_CYCLES(2), .PULSE_CYCLES(6)) dut2 (
        .CLK(CLK), .RESET(RESET), .BTN_IN(btn2), .INTR_EN(en), .CLR_CNT(clr),
        .INTR(intr2), .BTN_LEVEL(lvl2), .PRESS_CNT(cnt2)
    );

    // Reference model: hist holds BTN_IN as captured on each edge (bit 0 =
    // newest). The synchronised view at an edge is the capture two edges back;
    // the level flips once D+1 consecutive synchronised samples disagree with it.
    typedef struct {
        logic [31:0] hist;
        logic        level;
        logic [7:0]  cnt;
        int          rem;
    } mdl_t;

    mdl_t m1, m2;

    task automatic mdl_reset(output mdl_t m);
        m.hist  = '0;
        m.level = 1'b0;
        m.cnt   = 8'd0;
        m.rem   = 0;
    endtask

    task automatic mdl_step(inout mdl_t m, input logic b, input logic e,
                            input logic c, input int d, input int p);
        logic press, flip;
        m.hist = {m.hist[30:0], b};
        flip = 1'b1;
        for (int i = 2; i <= 2 + d; i++)
            if (m.hist[i] == m.level) flip = 1'b0;
        press = 1'b0;
        if (flip) begin
            m.level = ~m.level;
            press   = m.level;
        end
        if (c)          m.cnt = 8'd0;
        else if (press) m.cnt = m.cnt + 8'd1;
        if (press && e)    m.rem = p;
        else if (m.rem > 0) m.rem = m.rem - 1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 20)
                $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cmp_models();
        check("lvl1", 32'(lvl1), 32'(m1.level));
        check("cnt1", 32'(cnt1), 32'(m1.cnt));
        check("intr1", 32'(intr1), 32'(m1.rem > 0));
        check("lvl2", 32'(lvl2), 32'(m2.level));
        check("cnt2", 32'(cnt2), 32'(m2.cnt));
        check("intr2", 32'(intr2), 32'(m2.rem > 0));
    endtask

    // One clock: models follow the edge, outputs sampled on the falling edge
    task automatic tick();
        @(posedge CLK);
        mdl_step(m1, btn1, en, clr, 4, 3);
        mdl_step(m2, btn2, en, clr, 2, 6);
        @(negedge CLK);
        cmp_models();
    endtask

    task automatic hold(input int n);
        repeat (n) tick();
    endtask

    // Let an edge happen, then assert reset asynchronously between edges
    task automatic reset_after_edge(input string tag);
        @(posedge CLK);
        mdl_step(m1, btn1, en, clr, 4, 3);
        mdl_step(m2, btn2, en, clr, 2, 6);
        #2 RESET = 1'b1;
        mdl_reset(m1);
        mdl_reset(m2);
        #1;
        check({tag, "_intr"}, 32'(intr1), 32'd0);
        check({tag, "_lvl"},  32'(lvl1),  32'd0);
        check({tag, "_cnt"},  32'(cnt1),  32'd0);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    // Held button after reset release: one press at edge 6, pulse on 6..8
    task automatic post_reset_press(input string tag);
        for (int k = 0; k < 10; k++) begin
            tick();
            check({tag, "_lvl"},  32'(lvl1),  32'(k >= 6));
            check({tag, "_intr"}, 32'(intr1), 32'(k >= 6 && k <= 8));
            check({tag, "_cnt"},  32'(cnt1),  32'(k >= 6 ? 1 : 0));
        end
    endtask

    int hi_cnt;

    initial begin
        RESET = 1'b1; btn1 = 1'b0; btn2 = 1'b0; en = 1'b0; clr = 1'b0;
        mdl_reset(m1);
        mdl_reset(m2);
        #2;
        check("rst_intr1", 32'(intr1), 32'd0);
        check("rst_lvl1",  32'(lvl1),  32'd0);
        check("rst_cnt1",  32'(cnt1),  32'd0);
        check("rst_intr2", 32'(intr2), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        hold(3);

        // Clean press with interrupts enabled
        en = 1'b1; btn1 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("clean_lvl",  32'(lvl1),  32'(k >= 6));
            check("clean_cnt",  32'(cnt1),  32'(k >= 6 ? 1 : 0));
            check("clean_intr", 32'(intr1), 32'(k >= 6 && k <= 8));
        end
        btn1 = 1'b0; hold(10);

        // Bounce: high 3, low 1, then steady high -> a single event
        hi_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            btn1 = (k != 3);
            tick();
            if (intr1) hi_cnt++;
            check("bounce_lvl", 32'(lvl1), 32'(k >= 10));
        end
        check("bounce_pulse", 32'(hi_cnt), 32'd3);
        check("bounce_cnt", 32'(cnt1), 32'd2);
        btn1 = 1'b0; hold(10);

        // Press while disabled, then enable: count only, no interrupt
        en = 1'b0; btn1 = 1'b1; hi_cnt = 0;
        for (int k = 0; k < 10; k++) begin tick(); if (intr1) hi_cnt++; end
        en = 1'b1;
        for (int k = 0; k < 6; k++) begin tick(); if (intr1) hi_cnt++; end
        check("dis_pulse", 32'(hi_cnt), 32'd0);
        check("dis_cnt", 32'(cnt1), 32'd3);
        btn1 = 1'b0; hold(10);
        btn1 = 1'b1; hi_cnt = 0;
        for (int k = 0; k < 12; k++) begin tick(); if (intr1) hi_cnt++; end
        check("reen_pulse", 32'(hi_cnt), 32'd3);
        check("reen_cnt", 32'(cnt1), 32'd4);
        btn1 = 1'b0; hold(10);

        // Clear coincident with press: count cleared, interrupt still fires
        btn1 = 1'b1;
        hold(6);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clrpress_cnt", 32'(cnt1), 32'd0);
        check("clrpress_intr", 32'(intr1), 32'd1);
        hold(4);
        btn1 = 1'b0; hold(10);

        // 256 presses wrap the counter back to zero
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 256; i++) begin
            btn1 = 1'b1; hold(8);
            if (i == 254) check("wrap_255", 32'(cnt1), 32'd255);
            btn1 = 1'b0; hold(8);
        end
        check("wrap_0", 32'(cnt1), 32'd0);

        // Reset mid-pulse with the button held
        btn1 = 1'b1;
        hold(7);
        reset_after_edge("rst_pulse");
        post_reset_press("held_a");
        btn1 = 1'b0; hold(10);

        // Reset mid-debounce with the button held
        btn1 = 1'b1;
        hold(4);
        reset_after_edge("rst_db");
        post_reset_press("held_b");
        btn1 = 1'b0; hold(10);

        // Short debounce, long pulse: second press retriggers the pulse
        for (int k = 0; k < 18; k++) begin
            btn2 = (k < 3) || (k >= 6);
            tick();
            check("retrig_intr", 32'(intr2), 32'(k >= 4 && k <= 15));
            check("retrig_lvl", 32'(lvl2), 32'((k >= 4 && k <= 6) || k >= 10));
        end
        btn2 = 1'b0; hold(8);

        // Randomised traffic against the model, with a few async resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) btn1 = ~btn1;
            if ($urandom_range(0, 2) == 0) btn2 = ~btn2;
            if ($urandom_range(0, 40) == 0) en = ~en;
            clr = ($urandom_range(0, 31) == 0);
            if (i % 1000 == 999) reset_after_edge("rnd_rst");
            else tick();
        end
        clr = 1'b0;
        hold(4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
